// File: rtl/ym_eg_regif.sv
// CPU register file for the envelope generator: parameter RAM, key events, busy/overrun status (opt. YM_REGIF_OVERRUN_EN).
// Latency: envelope read returns one phiM cycle after eg_req; busy asserts the cycle after a data write.
// Backpressure: none on the read side; CPU data writes during busy are dropped.
module ym_eg_regif #(
  parameter int BUSY_CYCLES = 64
) (
  input  logic       phiM,
  input  logic       IC_b,
  input  logic       CS_b,
  input  logic       WR_b,
  input  logic       A0,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  input  logic [4:0] eg_slot,
  input  logic       eg_req,
  output logic [6:0] total_level,
  output logic [4:0] attack_rate,
  output logic [4:0] first_decay_rate,
  output logic [4:0] second_decay_rate,
  output logic [3:0] first_decay_level,
  output logic [3:0] release_rate,
  output logic       note_on,
  output logic       note_off,
  output logic       eg_valid
);

  localparam int CW = $clog2(BUSY_CYCLES + 1);

  logic [CW-1:0] busy_cnt;
  logic          busy;
  logic          strobe, strobe_q, accept, data_ok, key_wr, ovr_bit;
  logic [7:0]    addr_q;
  logic [3:0]    key_bit;
  logic [4:0]    key_idx [4];

  logic [6:0] tl_mem  [32];
  logic [4:0] ar_mem  [32];
  logic [4:0] d1r_mem [32];
  logic [4:0] d2r_mem [32];
  logic [3:0] d1l_mem [32];
  logic [3:0] rr_mem  [32];
  logic [31:0] key_state, pend_on, pend_off;

  assign busy    = (busy_cnt != '0);
  assign strobe  = !CS_b && !WR_b;
  assign accept  = strobe && !strobe_q;
  assign data_ok = accept && A0 && !busy;
  assign key_wr  = data_ok && (addr_q == 8'h08);
  // Key mask bits are not in device order: bit3=DEV0, bit5=DEV1, bit4=DEV2, bit6=DEV3.
  assign key_bit = {D_in[6], D_in[4], D_in[5], D_in[3]};

  always_comb begin
    key_idx = '{default: '0};
    for (int d = 0; d < 4; d++) key_idx[d] = {2'(d), D_in[2:0]};
  end

  // Strobe history resets high so a strobe held through reset needs a fresh edge.
  always_ff @(posedge phiM) begin
    if (!IC_b) begin
      strobe_q <= 1'b1;
      addr_q   <= 8'h00;
      busy_cnt <= '0;
    end else begin
      strobe_q <= strobe;
      if (accept && !A0) addr_q <= D_in;
      if (data_ok)   busy_cnt <= CW'(BUSY_CYCLES);
      else if (busy) busy_cnt <= busy_cnt - CW'(1);
    end
  end

`ifdef YM_REGIF_OVERRUN_EN
  logic overrun;
  always_ff @(posedge phiM) begin
    if (!IC_b)                   overrun <= 1'b0;
    else if (accept && !A0)      overrun <= 1'b0;
    else if (accept && A0 && busy) overrun <= 1'b1;
  end
  assign ovr_bit = overrun;
`else
  assign ovr_bit = 1'b0;
`endif

  assign D_out = {busy, ovr_bit, 6'b0};

  always_ff @(posedge phiM) begin
    if (!IC_b) begin
      for (int s = 0; s < 32; s++) begin
        tl_mem[s]  <= '0;
        ar_mem[s]  <= '0;
        d1r_mem[s] <= '0;
        d2r_mem[s] <= '0;
        d1l_mem[s] <= '0;
        rr_mem[s]  <= '0;
      end
    end else if (data_ok) begin
      case (addr_q[7:5])
        3'b011: tl_mem[addr_q[4:0]]  <= D_in[6:0];
        3'b100: ar_mem[addr_q[4:0]]  <= D_in[4:0];
        3'b101: d1r_mem[addr_q[4:0]] <= D_in[4:0];
        3'b110: d2r_mem[addr_q[4:0]] <= D_in[4:0];
        3'b111: begin
          d1l_mem[addr_q[4:0]] <= D_in[7:4];
          rr_mem[addr_q[4:0]]  <= D_in[3:0];
        end
        default: ;
      endcase
    end
  end

  // Read clear comes first so a same-cycle key event on the read slot survives.
  always_ff @(posedge phiM) begin
    if (!IC_b) begin
      key_state <= '0;
      pend_on   <= '0;
      pend_off  <= '0;
    end else begin
      if (eg_req) begin
        pend_on[eg_slot]  <= 1'b0;
        pend_off[eg_slot] <= 1'b0;
      end
      if (key_wr) begin
        for (int d = 0; d < 4; d++) begin
          if (key_bit[d] != key_state[key_idx[d]]) begin
            key_state[key_idx[d]] <= key_bit[d];
            pend_on[key_idx[d]]   <= key_bit[d];
            pend_off[key_idx[d]]  <= !key_bit[d];
          end
        end
      end
    end
  end

  always_ff @(posedge phiM) begin
    if (!IC_b) begin
      eg_valid          <= 1'b0;
      note_on           <= 1'b0;
      note_off          <= 1'b0;
      total_level       <= '0;
      attack_rate       <= '0;
      first_decay_rate  <= '0;
      second_decay_rate <= '0;
      first_decay_level <= '0;
      release_rate      <= '0;
    end else begin
      eg_valid <= eg_req;
      note_on  <= eg_req && pend_on[eg_slot];
      note_off <= eg_req && pend_off[eg_slot];
      if (eg_req) begin
        total_level       <= tl_mem[eg_slot];
        attack_rate       <= ar_mem[eg_slot];
        first_decay_rate  <= d1r_mem[eg_slot];
        second_decay_rate <= d2r_mem[eg_slot];
        first_decay_level <= d1l_mem[eg_slot];
        release_rate      <= rr_mem[eg_slot];
      end
    end
  end

endmodule

// File: tb/tb_ym_eg_regif.sv
// Directed bench for ym_eg_regif; envelope reads are checked through an expected-value queue.
module tb_ym_eg_regif;
  localparam int BUSY = 64;
`ifdef YM_REGIF_OVERRUN_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  logic       phiM = 1'b0;
  logic       IC_b = 1'b0, CS_b = 1'b1, WR_b = 1'b1, A0 = 1'b0, eg_req = 1'b0;
  logic [7:0] D_in = 8'h00;
  logic [4:0] eg_slot = 5'd0;
  logic [7:0] D_out;
  logic [6:0] total_level;
  logic [4:0] attack_rate, first_decay_rate, second_decay_rate;
  logic [3:0] first_decay_level, release_rate;
  logic       note_on, note_off, eg_valid;

  typedef struct packed {
    logic [6:0] tl; logic [4:0] ar; logic [4:0] d1r; logic [4:0] d2r;
    logic [3:0] d1l; logic [3:0] rr; logic on; logic off;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   n;

  ym_eg_regif #(.BUSY_CYCLES(BUSY)) dut (
    .phiM(phiM), .IC_b(IC_b), .CS_b(CS_b), .WR_b(WR_b), .A0(A0), .D_in(D_in), .D_out(D_out),
    .eg_slot(eg_slot), .eg_req(eg_req), .total_level(total_level), .attack_rate(attack_rate),
    .first_decay_rate(first_decay_rate), .second_decay_rate(second_decay_rate),
    .first_decay_level(first_decay_level), .release_rate(release_rate),
    .note_on(note_on), .note_off(note_off), .eg_valid(eg_valid)
  );

  always #5 phiM = ~phiM;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [6:0] tl, input logic [4:0] ar, input logic [4:0] d1r,
                              input logic [4:0] d2r, input logic [3:0] d1l, input logic [3:0] rr,
                              input logic on, input logic off);
    return {tl, ar, d1r, d2r, d1l, rr, on, off};
  endfunction

  function automatic logic [31:0] got();
    return {total_level, attack_rate, first_decay_rate, second_decay_rate,
            first_decay_level, release_rate, note_on, note_off};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge phiM);
    #1;
  endtask

  task automatic cpu_write(input logic a0, input logic [7:0] d);
    CS_b = 1'b1; WR_b = 1'b1;
    tick();
    CS_b = 1'b0; WR_b = 1'b0; A0 = a0; D_in = d;
    tick();
    CS_b = 1'b1; WR_b = 1'b1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (D_out[7] && cycles < 300) begin
      tick();
      cycles++;
    end
    chk("idle", {31'd0, D_out[7]}, 32'd0);
  endtask

  // Called on the cycle the DUT should present read data.
  task automatic check_out(input string tag);
    exp_t e;
    logic [31:0] g;
    g = got();
    chk({tag, "_valid"}, {31'd0, eg_valid}, 32'd1);
    chk({tag, "_sb"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_params"}, {2'b0, g[31:2]}, {2'b0, e[31:2]});
      chk({tag, "_note_on"}, {31'd0, note_on}, {31'd0, e.on});
      chk({tag, "_note_off"}, {31'd0, note_off}, {31'd0, e.off});
    end
  endtask

  task automatic read_slot(input string tag, input logic [4:0] slot, input exp_t e);
    logic [31:0] g;
    eg_slot = slot; eg_req = 1'b1;
    sb.push_back(e);
    tick();
    eg_req = 1'b0;
    check_out(tag);
    tick();
    g = got();
    chk({tag, "_drop"}, {31'd0, eg_valid}, 32'd0);
    chk({tag, "_hold"}, {2'b0, g[31:2]}, {2'b0, e[31:2]});
    chk({tag, "_quiet"}, {30'd0, note_on, note_off}, 32'd0);
  endtask

  // Data write accepted in the same cycle as a read of 'slot'.
  task automatic write_and_read(input string tag, input logic [7:0] d, input logic [4:0] slot,
                                input exp_t e);
    CS_b = 1'b1; WR_b = 1'b1;
    tick();
    CS_b = 1'b0; WR_b = 1'b0; A0 = 1'b1; D_in = d;
    eg_slot = slot; eg_req = 1'b1;
    sb.push_back(e);
    tick();
    CS_b = 1'b1; WR_b = 1'b1; eg_req = 1'b0;
    check_out(tag);
  endtask

  initial begin
    // Reset with a data strobe held low through release.
    IC_b = 1'b0; CS_b = 1'b0; WR_b = 1'b0; A0 = 1'b1; D_in = 8'h55;
    repeat (3) tick();
    chk("rst_dout", {24'd0, D_out}, 32'h00);
    chk("rst_valid", {31'd0, eg_valid}, 32'd0);
    chk("rst_outs", got(), 32'd0);
    IC_b = 1'b1;
    tick(); tick();
    chk("held_strobe", {24'd0, D_out}, 32'h00);
    CS_b = 1'b1; WR_b = 1'b1;

    // TL write and busy length.
    cpu_write(1'b0, 8'h65);
    chk("addr_no_busy", {24'd0, D_out}, 32'h00);
    cpu_write(1'b1, 8'h7F);
    chk("busy_set", {24'd0, D_out}, 32'h80);
    wait_idle(n);
    chk("busy_len", n, BUSY);
    read_slot("tl5", 5'd5, mk(7'h7F, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    write_and_read("tl5_same", 8'h22, 5'd5, mk(7'h7F, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    wait_idle(n);
    read_slot("tl5_new", 5'd5, mk(7'h22, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    cpu_write(1'b0, 8'h9F);
    cpu_write(1'b1, 8'hFF);
    wait_idle(n);
    read_slot("ar31", 5'd31, mk(0, 5'h1F, 0, 0, 0, 0, 1'b0, 1'b0));

    // D1L/RR write, then a data write during busy is dropped.
    cpu_write(1'b0, 8'hE3);
    cpu_write(1'b1, 8'hA6);
    repeat (10) tick();
    cpu_write(1'b1, 8'h11);
    chk("ovr_busy", {24'd0, D_out}, {24'd0, 1'b1, OV, 6'b0});
    wait_idle(n);
    chk("no_reload", n, BUSY - 12);
    chk("ovr_idle", {24'd0, D_out}, {24'd0, 1'b0, OV, 6'b0});
    read_slot("d1l3", 5'd3, mk(0, 0, 0, 0, 4'hA, 4'h6, 1'b0, 1'b0));
    cpu_write(1'b0, 8'h08);
    chk("ovr_clear", {24'd0, D_out}, 32'h00);

    // Key on/off across all four devices of channel 2.
    cpu_write(1'b1, 8'h7A);
    wait_idle(n);
    read_slot("on2", 5'd2, mk(0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    read_slot("on10", 5'd10, mk(0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    read_slot("on18", 5'd18, mk(0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    read_slot("on26", 5'd26, mk(0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    read_slot("on2_again", 5'd2, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    cpu_write(1'b1, 8'h02);
    wait_idle(n);
    read_slot("off2", 5'd2, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    read_slot("off10", 5'd10, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    read_slot("off18", 5'd18, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b1));
    read_slot("off26", 5'd26, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b1));

    // Key-on for slot 3 lands on the same cycle as a read holding a pending-off.
    cpu_write(1'b1, 8'h0B);
    wait_idle(n);
    read_slot("on3", 5'd3, mk(0, 0, 0, 0, 4'hA, 4'h6, 1'b1, 1'b0));
    cpu_write(1'b1, 8'h03);
    wait_idle(n);
    write_and_read("race3", 8'h0B, 5'd3, mk(0, 0, 0, 0, 4'hA, 4'h6, 1'b0, 1'b1));
    wait_idle(n);
    read_slot("race3_next", 5'd3, mk(0, 0, 0, 0, 4'hA, 4'h6, 1'b1, 1'b0));

    // Reset pulse mid-busy with pending key-ons outstanding.
    cpu_write(1'b1, 8'h7A);
    repeat (5) tick();
    chk("pre_rst_busy", {24'd0, D_out}, 32'h80);
    IC_b = 1'b0;
    tick();
    IC_b = 1'b1;
    chk("post_rst_dout", {24'd0, D_out}, 32'h00);
    read_slot("rst2", 5'd2, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    read_slot("rst3", 5'd3, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    read_slot("rst5", 5'd5, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    read_slot("rst26", 5'd26, mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
